// File: rtl/boid_fb_plotter_if.sv
// boid_fb_plotter_if: plot-request handshake plus framebuffer write port.
// master = boid processing side, slave = plotter.
interface boid_fb_plotter_if #(
    parameter int ID_WIDTH    = 4,
    parameter int COLOR_WIDTH = 8,
    parameter int ADDR_WIDTH  = 20
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ID_WIDTH-1:0]    req_id;
    logic [9:0]             req_x;
    logic [8:0]             req_y;
    logic [COLOR_WIDTH-1:0] req_color;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [COLOR_WIDTH-1:0] wr_data;

    modport master (
        output req_valid, req_id, req_x, req_y, req_color,
        input  req_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_id, req_x, req_y, req_color,
        output req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/boid_fb_plotter.sv
// boid_fb_plotter: erases each boid's previous pixel, then draws the new one.
// Define BOUNDS_CHECK_EN to drop off-screen requests (erase only, oob pulse).
module boid_fb_plotter #(
    parameter int VIDEO_WIDTH  = 640,
    parameter int VIDEO_HEIGHT = 480,
    parameter int ADDR_WIDTH   = 20,
    parameter int COLOR_WIDTH  = 8,
    parameter int NUM_BOIDS    = 16,
    parameter int ID_WIDTH     = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    boid_fb_plotter_if.slave       bus,
    input  logic [COLOR_WIDTH-1:0] bg_color,
    output logic                   busy,
    output logic                   oob
);

    if (VIDEO_WIDTH != 640) begin : g_width_check
        $error("boid_fb_plotter: address math needs VIDEO_WIDTH == 640");
    end
    if (ADDR_WIDTH < $clog2(VIDEO_WIDTH * VIDEO_HEIGHT)) begin : g_addr_check
        $error("boid_fb_plotter: ADDR_WIDTH too small for the screen");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ERASE,
        DRAW
    } state_t;

    state_t state_q, state_d;

    logic [ID_WIDTH-1:0]    id_q;
    logic [9:0]             x_q;
    logic [8:0]             y_q;
    logic [COLOR_WIDTH-1:0] color_q;
    logic [ADDR_WIDTH-1:0]  new_addr_q;
    logic                   skip_q, skip_d;

    logic [NUM_BOIDS-1:0]   tbl_valid_q;
    logic [ADDR_WIDTH-1:0]  tbl_addr_q [NUM_BOIDS];
    logic                   tbl_set, tbl_clr;

    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [COLOR_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   oob_q, oob_d;

    logic [ADDR_WIDTH-1:0]  x_ext, y_ext, calc_addr;
    logic [ADDR_WIDTH-1:0]  prev_addr;
    logic                   prev_valid;
    logic                   out_of_range;

    // y*640 + x as y*512 + y*128 + x
    assign x_ext     = ADDR_WIDTH'(x_q);
    assign y_ext     = ADDR_WIDTH'(y_q);
    assign calc_addr = (y_ext << 9) + (y_ext << 7) + x_ext;

    assign prev_addr  = tbl_addr_q[id_q];
    assign prev_valid = tbl_valid_q[id_q];

`ifdef BOUNDS_CHECK_EN
    assign out_of_range = (x_q >= 10'(VIDEO_WIDTH)) ||
                          (y_q >= 9'(VIDEO_HEIGHT));
`else
    assign out_of_range = 1'b0;
`endif

    assign bus.req_ready = (state_q == IDLE);
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign busy          = (state_q != IDLE);
    assign oob           = oob_q;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        oob_d     = 1'b0;
        skip_d    = skip_q;
        tbl_set   = 1'b0;
        tbl_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) state_d = CALC;
            end
            CALC: begin
                skip_d  = out_of_range;
                oob_d   = out_of_range;
                tbl_clr = out_of_range;
                if (prev_valid &&
                    (out_of_range || prev_addr != calc_addr)) begin
                    state_d   = ERASE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = prev_addr;
                    wr_data_d = bg_color;
                end else if (out_of_range) begin
                    state_d = IDLE;
                end else begin
                    state_d   = DRAW;
                    wr_en_d   = 1'b1;
                    wr_addr_d = calc_addr;
                    wr_data_d = color_q;
                end
            end
            ERASE: begin
                if (skip_q) begin
                    state_d = IDLE;
                end else begin
                    state_d   = DRAW;
                    wr_en_d   = 1'b1;
                    wr_addr_d = new_addr_q;
                    wr_data_d = color_q;
                end
            end
            DRAW: begin
                state_d = IDLE;
                tbl_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            oob_q     <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            oob_q     <= oob_d;
            skip_q    <= skip_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            color_q    <= '0;
            new_addr_q <= '0;
        end else begin
            if (state_q == IDLE && bus.req_valid) begin
                id_q    <= bus.req_id;
                x_q     <= bus.req_x;
                y_q     <= bus.req_y;
                color_q <= bus.req_color;
            end
            if (state_q == CALC) new_addr_q <= calc_addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tbl_valid_q <= '0;
            for (int i = 0; i < NUM_BOIDS; i++) tbl_addr_q[i] <= '0;
        end else if (tbl_set) begin
            tbl_valid_q[id_q] <= 1'b1;
            tbl_addr_q[id_q]  <= new_addr_q;
        end else if (tbl_clr) begin
            tbl_valid_q[id_q] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_boid_fb_plotter.sv
// tb_boid_fb_plotter: directed and random plot requests checked by a
// scoreboard fed from a screen-level model of erase/draw behaviour.
module tb_boid_fb_plotter;

`ifdef BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bg_color = 8'h00;
    logic       busy;
    logic       oob;

    boid_fb_plotter_if #(
        .ID_WIDTH(4), .COLOR_WIDTH(8), .ADDR_WIDTH(20)
    ) bus ();

    boid_fb_plotter dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .bg_color (bg_color),
        .busy     (busy),
        .oob      (oob)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int  checks = 0;
    int  failures = 0;
    wr_t sb[$];
    int  m_valid[16];
    int  m_addr[16];
    int  lx[16];
    int  ly[16];
    int  sent = 0;
    int  acc_seen = 0;
    int  oob_exp = 0;
    int  oob_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    // monitor: every framebuffer write must match the next expected one
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.wr_en) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: addr=%0d data=0x%0h cyc=%0d",
                             bus.wr_addr, bus.wr_data, cyc);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    if (int'(bus.wr_addr) != e.addr ||
                        int'(bus.wr_data) != e.data || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL write: got addr=%0d data=0x%0h cyc=%0d expected addr=%0d data=0x%0h cyc=%0d",
                                 bus.wr_addr, bus.wr_data, cyc,
                                 e.addr, e.data, e.cyc);
                    end
                end
            end
            if (oob) oob_seen++;
            if (bus.req_valid && bus.req_ready) acc_seen++;
        end
    end

    task automatic model(input int id, input int x, input int y,
                         input int color, input int t);
        int  addr;
        bit  off;
        addr = y * 640 + x;
        off  = BC && (x >= 640 || y >= 480);
        if (off) begin
            if (m_valid[id] != 0)
                sb.push_back('{m_addr[id], int'(bg_color), t + 1});
            m_valid[id] = 0;
            oob_exp++;
        end else begin
            if (m_valid[id] != 0 && m_addr[id] != addr) begin
                sb.push_back('{m_addr[id], int'(bg_color), t + 1});
                sb.push_back('{addr, color, t + 2});
            end else begin
                sb.push_back('{addr, color, t + 1});
            end
            m_valid[id] = 1;
            m_addr[id]  = addr;
        end
    endtask

    // leaves req_valid high; returns the cycle of the transfer edge
    task automatic send(input int id, input int x, input int y,
                        input int color, output int t);
        int n;
        bus.req_valid = 1'b1;
        bus.req_id    = 4'(id);
        bus.req_x     = 10'(x);
        bus.req_y     = 9'(y);
        bus.req_color = 8'(color);
        lx[id] = x;
        ly[id] = y;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: id=%0d not accepted in 50 cycles", id);
            t = -1;
        end else begin
            t = cyc + 1;
            model(id, x, y, color, t);
            sent++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_cyc(input int t);
        int n;
        n = 0;
        while (cyc < t && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
    endtask

    initial begin
        int t;
        int id, x, y;
        bus.req_valid = 1'b0;
        bus.req_id    = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_color = '0;
        clear_model();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        chk("rst_oob", int'(oob), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // first draw, empty table
        send(0, 100, 100, 'h1F, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 1);
        chk("draw_ready_low", int'(bus.req_ready), 0);
        chk("draw_busy", int'(busy), 1);
        wait_cyc(t + 2);
        chk("draw_ready_back", int'(bus.req_ready), 1);

        // move by one pixel: erase then draw
        send(0, 101, 100, 'h1F, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 2);
        chk("erase_ready_low", int'(bus.req_ready), 0);
        wait_cyc(t + 3);
        chk("erase_ready_back", int'(bus.req_ready), 1);

        // last pixel, repeated in place
        send(3, 639, 479, 'h2A, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 3);
        send(3, 639, 479, 'h2A, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 3);

        // back-to-back with valid held
        send(1, 5, 6, 'h11, t);
        send(2, 7, 8, 'h22, t);
        send(1, 9, 6, 'h33, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 4);

        // off-screen request
        send(0, 10, 10, 'h44, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 3);
        send(0, 640, 5, 'h45, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 1);
        chk("oob_pulse", int'(oob), int'(BC));
        wait_cyc(t + 2);
        chk("oob_one_cycle", int'(oob), 0);
        wait_cyc(t + 4);
        send(0, 12, 10, 'h46, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 4);

        // reset in the middle of an erase
        send(7, 20, 20, 'h55, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 3);
        send(7, 21, 20, 'h56, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 1);
        chk("erase_in_flight", int'(bus.wr_en), 1);
        chk("erase_addr", int'(bus.wr_addr), 20 * 640 + 20);
        reset = 1'b1;
        #1;
        chk("midrst_wr_en", int'(bus.wr_en), 0);
        chk("midrst_ready", int'(bus.req_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        clear_model();
        @(posedge clock);
        #1;
        reset = 1'b0;
        send(7, 22, 20, 'h57, t);
        bus.req_valid = 1'b0;
        wait_cyc(t + 4);

        // random traffic with id reuse and in-place repeats
        for (int i = 0; i < 200; i++) begin
            id = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0 && m_valid[id] != 0) begin
                x = lx[id];
                y = ly[id];
            end else begin
                x = $urandom_range(0, 700);
                y = $urandom_range(0, 511);
            end
            send(id, x, y, $urandom_range(0, 255), t);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(4, 8)) @(posedge clock);
                #1;
                bg_color = 8'($urandom_range(0, 255));
            end
        end
        bus.req_valid = 1'b0;

        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            @(posedge clock);
            #1;
        end
        repeat (2) @(posedge clock);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("accepted", acc_seen, sent);
        chk("oob_count", oob_seen, oob_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
